ext_mem_model: RTL and testbench
================================

Name: ext_mem_model

Overview:
Behavioural external main-memory model for the RISC-V processor testbench. It serves the processor's `riscv_top` memory port (request, write-data and response channels) with single-beat, tagged, fixed-latency reads and single-cycle masked writes. Backing storage lives in a sub-instance named `storage` that holds a word array named `mem`, so the bench can preload it with `$readmemh` into `<inst>.storage.mem`.

Parameters:
- MEM_DATA_BITS, 128: data-beat width. One address unit is one beat (16 bytes); byte address = {mem_req_addr, 4'd0}.
- MEM_ADDR_BITS, 28: width of the beat address.
- MEM_TAG_BITS, 5: width of the request/response tag.
- DEPTH_LOG2, 14: storage holds 2^DEPTH_LOG2 beats.
- LATENCY, 2: cycles from read acceptance to response; legal range is 1 and above.

Ports:
- clk, input, 1: clock; all logic on rising edge.
- reset, input, 1: synchronous, active-high reset.
- mem_req_valid, input, 1: request present.
- mem_req_ready, output, 1: model can accept a request.
- mem_req_rw, input, 1: 1 = write, 0 = read.
- mem_req_addr, input, MEM_ADDR_BITS: beat address.
- mem_req_tag, input, MEM_TAG_BITS: request tag, echoed on read response.
- mem_req_data_valid, input, 1: write data present.
- mem_req_data_ready, output, 1: model can accept write data.
- mem_req_data_bits, input, MEM_DATA_BITS: write data.
- mem_req_data_mask, input, MEM_DATA_BITS/8: byte enables; bit i covers data bits [8i+7:8i].
- mem_resp_valid, output, 1: read response valid (one-cycle pulse).
- mem_resp_data, output, MEM_DATA_BITS: read data.
- mem_resp_tag, output, MEM_TAG_BITS: tag of the answered read.

Behaviour:
- **Reset.**
  - While reset is high, at each edge: mem_req_ready=0, mem_req_data_ready=0, mem_resp_valid=0, mem_resp_data=0, mem_resp_tag=0.
  - Any pending read is discarded and never answered.
  - Storage contents are NOT cleared, so preloaded images survive reset.
- **Outputs are registered.** mem_req_data_ready is always equal to mem_req_ready.
- **Indexing.** Storage index = mem_req_addr[DEPTH_LOG2-1:0]. Upper address bits are ignored, so addresses alias modulo the depth.
- **States.**
  - IDLE: ready=1.
  - BUSY: counts LATENCY cycles; ready=0.
- **Read acceptance.** In IDLE, a read is accepted on the edge where mem_req_valid=1, mem_req_ready=1 and mem_req_rw=0.
  - The addressed beat and the tag are captured at that edge (snapshot).
  - The FSM enters BUSY and ready drops the next cycle.
- **Read response.**
  - If acceptance is in cycle T, mem_resp_valid=1 with the captured data and tag in cycle T+LATENCY, for exactly one cycle.
  - ready is 0 in cycles T+1 through T+LATENCY and returns to 1 in cycle T+LATENCY+1 (back to IDLE).
  - There is no backpressure on the response channel.
  - While not valid, resp_data and resp_tag hold their last values.
- **Write acceptance.** A write is accepted on the edge where mem_req_valid=1, mem_req_ready=1, mem_req_rw=1 and mem_req_data_valid=1.
  - Only bytes whose mask bit is 1 are updated.
  - The FSM stays IDLE; ready remains 1 next cycle.
  - No response is generated for a write.
- **Partial write handshakes.**
  - mem_req_valid with rw=1 but data_valid=0: nothing is accepted and nothing changes; the requester keeps holding.
  - data_valid without mem_req_valid: ignored.
- **Ordering.**
  - At most one request is accepted per cycle.
  - A read accepted the cycle after a write to the same index returns the written data.
- **Unknown inputs.** X/unknown inputs while ready=0 are ignored.
- **Reset mid-read.** Reset asserted in BUSY discards the pending read; no resp_valid pulse occurs. The model is in IDLE with ready=1 the cycle after reset deasserts.

Test Plan:
1. Preload storage.mem[5]=0x00112233_44556677_8899AABB_CCDDEEFF, release reset, read addr=5 tag=3 at cycle T -> resp_valid=1 only in cycle T+2 with that data and tag=3; ready=0 in T+1..T+2 and 1 in T+3.
2. Write addr=7, data=all 0xA5 bytes, mask=0xFFFF, then write addr=7, data=0x5A.., mask=0x000F, then read addr=7 -> response data has low 4 bytes 0x5A and upper 12 bytes 0xA5; no response for either write.
3. Hold valid=1, rw=1, data_valid=0 for 3 cycles, then raise data_valid -> storage unchanged until the data_valid cycle, and exactly one write occurs.
4. Accept a read, assert reset in the next cycle for 2 cycles -> no resp_valid at any time; ready=0 during reset and 1 the cycle after release.
5. Read addr=2^DEPTH_LOG2+5 -> returns the same data as addr 5 (aliasing); back-to-back reads tags 1 then 2 -> two separate responses, each exactly LATENCY cycles after its own acceptance.

Source files
------------

// File: rtl/ext_mem_model.sv
// Behavioural external main memory: tagged fixed-latency single-beat reads and
// single-cycle byte-masked writes, backed by a preloadable word array.

module ext_mem_model_storage #(
    parameter int DATA_BITS  = 128,
    parameter int DEPTH_LOG2 = 14
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [DEPTH_LOG2-1:0]   idx,
    input  logic [DATA_BITS-1:0]    wr_data,
    input  logic [DATA_BITS/8-1:0]  wr_mask,
    output logic [DATA_BITS-1:0]    rd_data
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Never reset, so images loaded before reset release survive it.
    logic [DATA_BITS-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < DATA_BITS / 8; i++) begin
                if (wr_mask[i]) begin
                    mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Combinational read, so a read the cycle after a write sees the new beat.
    assign rd_data = mem[idx];
endmodule

module ext_mem_model #(
    parameter int MEM_DATA_BITS = 128,
    parameter int MEM_ADDR_BITS = 28,
    parameter int MEM_TAG_BITS  = 5,
    parameter int DEPTH_LOG2    = 14,
    parameter int LATENCY       = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mem_req_valid,
    output logic                       mem_req_ready,
    input  logic                       mem_req_rw,
    input  logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
    input  logic [MEM_TAG_BITS-1:0]    mem_req_tag,
    input  logic                       mem_req_data_valid,
    output logic                       mem_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
    input  logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
    output logic                       mem_resp_valid,
    output logic [MEM_DATA_BITS-1:0]   mem_resp_data,
    output logic [MEM_TAG_BITS-1:0]    mem_resp_tag
);
    localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                     state, state_n;
    logic [CNT_W-1:0]           cnt, cnt_n;
    logic                       ready, ready_n;
    logic                       resp_valid, resp_valid_n;
    logic [MEM_DATA_BITS-1:0]   resp_data, resp_data_n;
    logic [MEM_TAG_BITS-1:0]    resp_tag, resp_tag_n;
    logic [MEM_DATA_BITS-1:0]   snap_data, snap_data_n;
    logic [MEM_TAG_BITS-1:0]    snap_tag, snap_tag_n;

    logic [DEPTH_LOG2-1:0]      idx;
    logic [MEM_DATA_BITS-1:0]   rd_data;
    logic                       req_fire;
    logic                       rd_accept;
    logic                       wr_accept;
    logic                       unused_addr_bits;

    // Upper address bits alias onto the same storage beat.
    assign idx              = mem_req_addr[DEPTH_LOG2-1:0];
    assign unused_addr_bits = ^mem_req_addr[MEM_ADDR_BITS-1:DEPTH_LOG2];

    // Handshake: a request moves only on an edge where ready (registered, IDLE
    // only) and valid are both 1; a write additionally needs data_valid in the
    // same cycle, otherwise the requester holds and nothing changes.
    assign req_fire  = !reset && (state == IDLE) && ready && mem_req_valid;
    assign rd_accept = req_fire && !mem_req_rw;
    assign wr_accept = req_fire && mem_req_rw && mem_req_data_valid;

    ext_mem_model_storage #(
        .DATA_BITS  (MEM_DATA_BITS),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) storage (
        .clk     (clk),
        .wr_en   (wr_accept),
        .idx     (idx),
        .wr_data (mem_req_data_bits),
        .wr_mask (mem_req_data_mask),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            ready      <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_tag   <= '0;
            snap_data  <= '0;
            snap_tag   <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            ready      <= ready_n;
            resp_valid <= resp_valid_n;
            resp_data  <= resp_data_n;
            resp_tag   <= resp_tag_n;
            snap_data  <= snap_data_n;
            snap_tag   <= snap_tag_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        ready_n      = ready;
        resp_valid_n = 1'b0;
        resp_data_n  = resp_data;
        resp_tag_n   = resp_tag;
        snap_data_n  = snap_data;
        snap_tag_n   = snap_tag;
        case (state)
            IDLE: begin
                ready_n = 1'b1;
                if (rd_accept) begin
                    state_n     = BUSY;
                    ready_n     = 1'b0;
                    cnt_n       = CNT_W'(LATENCY - 1);
                    snap_data_n = rd_data;
                    snap_tag_n  = mem_req_tag;
                    // With single-cycle latency the response leaves on the next edge.
                    if (LATENCY == 1) begin
                        resp_valid_n = 1'b1;
                        resp_data_n  = rd_data;
                        resp_tag_n   = mem_req_tag;
                    end
                end
            end
            BUSY: begin
                ready_n = 1'b0;
                // cnt counts cycles left until ready returns; 1 means respond next.
                if (cnt == CNT_W'(1)) begin
                    resp_valid_n = 1'b1;
                    resp_data_n  = snap_data;
                    resp_tag_n   = snap_tag;
                end
                if (cnt == '0) begin
                    state_n = IDLE;
                    ready_n = 1'b1;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                ready_n = 1'b0;
            end
        endcase
    end

    assign mem_req_ready      = ready;
    assign mem_req_data_ready = ready;
    assign mem_resp_valid     = resp_valid;
    assign mem_resp_data      = resp_data;
    assign mem_resp_tag       = resp_tag;
endmodule

// File: tb/tb_ext_mem_model.sv
// Directed bench for ext_mem_model: reads, masked writes, held write handshakes,
// reset during a pending read, address aliasing and back-to-back reads.

module tb_ext_mem_model;
    localparam int DB  = 128;
    localparam int AB  = 28;
    localparam int TW  = 5;
    localparam int DL  = 14;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic            mem_req_rw;
    logic [AB-1:0]   mem_req_addr;
    logic [TW-1:0]   mem_req_tag;
    logic            mem_req_data_valid;
    logic            mem_req_data_ready;
    logic [DB-1:0]   mem_req_data_bits;
    logic [DB/8-1:0] mem_req_data_mask;
    logic            mem_resp_valid;
    logic [DB-1:0]   mem_resp_data;
    logic [TW-1:0]   mem_resp_tag;

    int n_cmp = 0;
    int n_err = 0;
    int resp_pulses = 0;

    logic [DB-1:0] d5     = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    logic [DB-1:0] d_a5   = {16{8'hA5}};
    logic [DB-1:0] d_5a   = {16{8'h5A}};
    logic [DB-1:0] d_mix  = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_5A5A5A5A;
    logic [DB-1:0] d_old  = 128'h11111111_22222222_33333333_44444444;
    logic [DB-1:0] d_new  = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    logic [DB-1:0] d_junk = 128'h0BADF00D_0BADF00D_0BADF00D_0BADF00D;

    ext_mem_model #(
        .MEM_DATA_BITS (DB),
        .MEM_ADDR_BITS (AB),
        .MEM_TAG_BITS  (TW),
        .DEPTH_LOG2    (DL),
        .LATENCY       (LAT)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_rw         (mem_req_rw),
        .mem_req_addr       (mem_req_addr),
        .mem_req_tag        (mem_req_tag),
        .mem_req_data_valid (mem_req_data_valid),
        .mem_req_data_ready (mem_req_data_ready),
        .mem_req_data_bits  (mem_req_data_bits),
        .mem_req_data_mask  (mem_req_data_mask),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_data      (mem_resp_data),
        .mem_resp_tag       (mem_resp_tag)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    always @(negedge clk) begin
        if (mem_resp_valid === 1'b1) resp_pulses++;
    end

    task automatic check_eq(input string tag, input logic [DB-1:0] got, input logic [DB-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver tasks
    task automatic do_write(input logic [AB-1:0] addr, input logic [DB-1:0] data,
                            input logic [DB/8-1:0] mask, input string name);
        mem_req_valid      = 1'b1;
        mem_req_rw         = 1'b1;
        mem_req_addr       = addr;
        mem_req_data_valid = 1'b1;
        mem_req_data_bits  = data;
        mem_req_data_mask  = mask;
        tick();
        mem_req_valid      = 1'b0;
        mem_req_data_valid = 1'b0;
        check_eq({name, "_ready"}, DB'(mem_req_ready), DB'(1));
        check_eq({name, "_no_resp"}, DB'(mem_resp_valid), DB'(0));
    endtask

    task automatic do_read(input logic [AB-1:0] addr, input logic [TW-1:0] tag,
                           input logic [DB-1:0] exp_data, input string name);
        int waited = 0;
        while (mem_req_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (waited >= 20) check_eq({name, "_ready_timeout"}, DB'(mem_req_ready), DB'(1));
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b0;
        mem_req_addr  = addr;
        mem_req_tag   = tag;
        tick();
        mem_req_valid = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            check_eq($sformatf("%s_busy_rdy_T%0d", name, k), DB'(mem_req_ready), DB'(0));
            check_eq($sformatf("%s_dready_T%0d", name, k), DB'(mem_req_data_ready), DB'(0));
            check_eq($sformatf("%s_rvalid_T%0d", name, k), DB'(mem_resp_valid), DB'(k == LAT));
            if (k == LAT) begin
                check_eq({name, "_data"}, mem_resp_data, exp_data);
                check_eq({name, "_tag"}, DB'(mem_resp_tag), DB'(tag));
            end else begin
                tick();
            end
        end
        tick();
        check_eq({name, "_ready_back"}, DB'(mem_req_ready), DB'(1));
        check_eq({name, "_rvalid_drop"}, DB'(mem_resp_valid), DB'(0));
    endtask

    initial begin
        int p0;
        reset              = 1'b1;
        mem_req_valid      = 1'b0;
        mem_req_rw         = 1'b0;
        mem_req_addr       = '0;
        mem_req_tag        = '0;
        mem_req_data_valid = 1'b0;
        mem_req_data_bits  = '0;
        mem_req_data_mask  = '0;

        dut.storage.mem[5] = d5;
        repeat (3) tick();
        check_eq("rst_ready", DB'(mem_req_ready), DB'(0));
        check_eq("rst_dready", DB'(mem_req_data_ready), DB'(0));
        check_eq("rst_rvalid", DB'(mem_resp_valid), DB'(0));
        check_eq("rst_rdata", mem_resp_data, DB'(0));
        check_eq("rst_rtag", DB'(mem_resp_tag), DB'(0));
        reset = 1'b0;
        tick();
        check_eq("post_rst_ready", DB'(mem_req_ready), DB'(1));

        // Preloaded read with tag 3
        do_read(AB'(5), TW'(3), d5, "rd5");

        // Full write, partial overwrite, then read the cycle after the last write
        p0 = resp_pulses;
        do_write(AB'(7), d_a5, 16'hFFFF, "wr7_full");
        do_write(AB'(7), d_5a, 16'h000F, "wr7_low");
        do_read(AB'(7), TW'(9), d_mix, "rd7");
        tick();
        check_eq("wr_no_extra_resp", DB'(resp_pulses), DB'(p0 + 1));

        // Write held without data_valid changes nothing until data_valid rises
        do_write(AB'(9), d_old, 16'hFFFF, "wr9_init");
        mem_req_valid      = 1'b1;
        mem_req_rw         = 1'b1;
        mem_req_addr       = AB'(9);
        mem_req_data_bits  = d_new;
        mem_req_data_mask  = 16'hFFFF;
        mem_req_data_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("hold_mem_%0d", i), dut.storage.mem[9], d_old);
            check_eq($sformatf("hold_ready_%0d", i), DB'(mem_req_ready), DB'(1));
        end
        mem_req_data_valid = 1'b1;
        tick();
        mem_req_valid      = 1'b0;
        mem_req_data_valid = 1'b0;
        check_eq("hold_written", dut.storage.mem[9], d_new);
        mem_req_data_bits  = d_junk;
        mem_req_data_valid = 1'b1;
        tick();
        mem_req_data_valid = 1'b0;
        check_eq("dvalid_alone_ignored", dut.storage.mem[9], d_new);
        do_read(AB'(9), TW'(17), d_new, "rd9");

        // Reset during a pending read discards it
        tick();
        p0 = resp_pulses;
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b0;
        mem_req_addr  = AB'(5);
        mem_req_tag   = TW'(4);
        tick();
        mem_req_valid = 1'b0;
        reset = 1'b1;
        tick();
        check_eq("midrst_ready_0", DB'(mem_req_ready), DB'(0));
        check_eq("midrst_rvalid_0", DB'(mem_resp_valid), DB'(0));
        tick();
        check_eq("midrst_ready_1", DB'(mem_req_ready), DB'(0));
        check_eq("midrst_rvalid_1", DB'(mem_resp_valid), DB'(0));
        check_eq("midrst_rtag", DB'(mem_resp_tag), DB'(0));
        reset = 1'b0;
        tick();
        check_eq("midrst_ready_back", DB'(mem_req_ready), DB'(1));
        repeat (3) tick();
        check_eq("midrst_no_resp", DB'(resp_pulses), DB'(p0));

        // Aliasing and back-to-back tagged reads
        do_read(AB'((1 << DL) + 5), TW'(6), d5, "rd_alias");
        do_read(AB'(5), TW'(1), d5, "rd_b2b_1");
        do_read(AB'(7), TW'(2), d_mix, "rd_b2b_2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
